// File: rtl/dcache_pkg.sv
// Shared widths, state encoding and bundles for the data cache controller.
// Address split: tag [31:9], index [8:5], word offset [4:2].
package dcache_pkg;

  localparam int ADDR_W = 32;
  localparam int TAG_W  = 23;
  localparam int IDX_W  = 4;
  localparam int OFF_W  = 3;
  localparam int LINE_W = 256;
  localparam int WORD_W = 32;
  localparam int STAG_W = TAG_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MISS,
    ST_WRITEBACK,
    ST_READMISS,
    ST_READMISSOK
  } state_e;

  typedef struct packed {
    logic              en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } mem_req_t;

  function automatic logic [ADDR_W-1:0] line_addr(
    input logic [TAG_W-1:0] tag,
    input logic [IDX_W-1:0] idx
  );
    return {tag, idx, 5'b0};
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU, memory and SRAM buses of the data cache controller.
// slave: controller side; master: CPU/memory/SRAM side.
interface dcache_if;
  import dcache_pkg::*;

  logic [ADDR_W-1:0] cpu_addr_i;
  logic [WORD_W-1:0] cpu_data_i;
  logic              cpu_MemRead_i;
  logic              cpu_MemWrite_i;
  logic [WORD_W-1:0] cpu_data_o;
  logic              cpu_stall_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  logic [IDX_W-1:0]  sram_index_o;
  logic [STAG_W-1:0] sram_tag_o;
  logic [LINE_W-1:0] sram_data_o;
  logic              sram_enable_o;
  logic              sram_write_o;
  logic              sram_write_hit_o;
  logic [STAG_W-1:0] sram_tag_i;
  logic [LINE_W-1:0] sram_data_i;
  logic              sram_hit_i;

  modport slave (
    input  cpu_addr_i, cpu_data_i,
    input  cpu_MemRead_i, cpu_MemWrite_i,
    output cpu_data_o, cpu_stall_o,
    output mem_addr_o, mem_data_o,
    output mem_enable_o, mem_write_o,
    input  mem_data_i, mem_ack_i,
    output sram_index_o, sram_tag_o,
    output sram_data_o, sram_enable_o,
    output sram_write_o, sram_write_hit_o,
    input  sram_tag_i, sram_data_i,
    input  sram_hit_i
  );

  modport master (
    output cpu_addr_i, cpu_data_i,
    output cpu_MemRead_i, cpu_MemWrite_i,
    input  cpu_data_o, cpu_stall_o,
    input  mem_addr_o, mem_data_o,
    input  mem_enable_o, mem_write_o,
    output mem_data_i, mem_ack_i,
    input  sram_index_o, sram_tag_o,
    input  sram_data_o, sram_enable_o,
    input  sram_write_o, sram_write_hit_o,
    output sram_tag_i, sram_data_i,
    output sram_hit_i
  );

endinterface

// File: rtl/dcache_word_mux.sv
// Selects one word of a cache line and builds the line with
// that word replaced by store data.
module dcache_word_mux
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [OFF_W-1:0]  off,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic [LINE_W-1:0] merged
);

  logic [7:0] base;

  assign base  = {off, 5'b0};
  assign rdata = line[base +: WORD_W];

  always_comb begin
    merged = line;
    merged[base +: WORD_W] = wdata;
  end

endmodule

// File: rtl/dcache_controller.sv
// Write-back data cache controller: hits complete in IDLE,
// misses write back a dirty victim, refill, then retry.
module dcache_controller
  import dcache_pkg::*;
(
  input logic     clk_i,
  input logic     rst_i,
  dcache_if.slave bus
);

  logic              req;
  logic              hit;
  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [WORD_W-1:0] rdata;
  logic [LINE_W-1:0] merged;

  state_e   state_q, state_d;
  mem_req_t mem_q, mem_d;

  logic              sram_wr;
  logic              sram_wr_hit;
  logic [STAG_W-1:0] sram_tag;
  logic [LINE_W-1:0] sram_data;

  assign req     = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign hit     = bus.sram_hit_i;
  assign cpu_tag = bus.cpu_addr_i[31:9];
  assign idx     = bus.cpu_addr_i[8:5];
  assign off     = bus.cpu_addr_i[4:2];

  dcache_word_mux u_mux (
    .line   (bus.sram_data_i),
    .off    (off),
    .wdata  (bus.cpu_data_i),
    .rdata  (rdata),
    .merged (merged)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    sram_wr     = 1'b0;
    sram_wr_hit = 1'b0;
    sram_tag    = {2'b10, cpu_tag};
    sram_data   = merged;
    unique case (state_q)
      ST_IDLE: begin
        if (req && !hit) begin
          state_d = ST_MISS;
        end else if (bus.cpu_MemWrite_i && hit) begin
          sram_wr     = 1'b1;
          sram_wr_hit = 1'b1;
          sram_tag    = {2'b11, cpu_tag};
        end
      end
      ST_MISS: begin
        mem_d.en = 1'b1;
        if (bus.sram_tag_i[24:23] == 2'b11) begin
          mem_d.wr   = 1'b1;
          mem_d.addr = line_addr(bus.sram_tag_i[22:0], idx);
          mem_d.data = bus.sram_data_i;
          state_d    = ST_WRITEBACK;
        end else begin
          mem_d.wr   = 1'b0;
          mem_d.addr = line_addr(cpu_tag, idx);
          state_d    = ST_READMISS;
        end
      end
      ST_WRITEBACK: begin
        if (bus.mem_ack_i) begin
          mem_d.wr   = 1'b0;
          mem_d.addr = line_addr(cpu_tag, idx);
          state_d    = ST_READMISS;
        end
      end
      ST_READMISS: begin
        if (bus.mem_ack_i) begin
          mem_d.en  = 1'b0;
          sram_wr   = 1'b1;
          sram_tag  = {2'b10, cpu_tag};
          sram_data = bus.mem_data_i;
          state_d   = ST_READMISSOK;
        end
      end
      ST_READMISSOK: state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  assign bus.cpu_data_o  = rdata;
  assign bus.cpu_stall_o = (req & ~hit) | (state_q != ST_IDLE);

  assign bus.mem_enable_o = mem_q.en;
  assign bus.mem_write_o  = mem_q.wr;
  assign bus.mem_addr_o   = mem_q.addr;
  assign bus.mem_data_o   = mem_q.data;

  // Strobes are gated so reset also blocks an IDLE store hit.
  assign bus.sram_index_o     = idx;
  assign bus.sram_enable_o    = req;
  assign bus.sram_write_o     = sram_wr & ~rst_i;
  assign bus.sram_write_hit_o = sram_wr_hit & ~rst_i;
  assign bus.sram_tag_o       = sram_tag;
  assign bus.sram_data_o      = sram_data;

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller with a 2-way SRAM
// model and a fixed-latency memory model.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if bus();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] line_pat(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = (a & 32'h00FF_FFFF) | (32'(w + 1) << 28);
    return l;
  endfunction

  // SRAM model: 16 sets x 2 ways, invalid-first then LRU victim
  logic [TAG_W-1:0]  s_tag  [16][2];
  logic              s_v    [16][2];
  logic              s_d    [16][2];
  logic [LINE_W-1:0] s_line [16][2];
  logic              s_lru  [16];

  logic              pre_en, pre_clr, pre_way, pre_lru;
  logic [3:0]        pre_idx;
  logic [STAG_W-1:0] pre_tag;
  logic [LINE_W-1:0] pre_line;

  logic       h0, h1, m_hit, m_way;
  logic [3:0] si;

  always_comb begin
    si = bus.sram_index_o;
    h0 = s_v[si][0] && (s_tag[si][0] == bus.sram_tag_o[22:0]);
    h1 = s_v[si][1] && (s_tag[si][1] == bus.sram_tag_o[22:0]);
    m_hit = h0 | h1;
    if (h0)              m_way = 1'b0;
    else if (h1)         m_way = 1'b1;
    else if (!s_v[si][0]) m_way = 1'b0;
    else if (!s_v[si][1]) m_way = 1'b1;
    else                 m_way = s_lru[si];
    bus.sram_hit_i  = m_hit;
    bus.sram_tag_i  = {s_v[si][m_way], s_d[si][m_way], s_tag[si][m_way]};
    bus.sram_data_i = s_line[si][m_way];
  end

  always @(posedge clk) begin
    if (pre_clr) begin
      for (int i = 0; i < 16; i++) begin
        s_lru[i] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          s_v[i][w]    <= 1'b0;
          s_d[i][w]    <= 1'b0;
          s_tag[i][w]  <= '0;
          s_line[i][w] <= '0;
        end
      end
    end else if (pre_en) begin
      s_v[pre_idx][pre_way]    <= pre_tag[24];
      s_d[pre_idx][pre_way]    <= pre_tag[23];
      s_tag[pre_idx][pre_way]  <= pre_tag[22:0];
      s_line[pre_idx][pre_way] <= pre_line;
      s_lru[pre_idx]           <= pre_lru;
    end else if (bus.sram_enable_o) begin
      if (bus.sram_write_o) begin
        s_v[si][m_way]    <= bus.sram_tag_o[24];
        s_d[si][m_way]    <= bus.sram_tag_o[23];
        s_tag[si][m_way]  <= bus.sram_tag_o[22:0];
        s_line[si][m_way] <= bus.sram_data_o;
        s_lru[si]         <= ~m_way;
      end else if (m_hit) begin
        s_lru[si] <= ~m_way;
      end
    end
  end

  // Memory model: ack arrives in the lat-th cycle of a request
  int   lat = 5;
  int   cnt;
  logic ack_q;
  logic inj_ack = 1'b0;

  assign bus.mem_ack_i = ack_q | inj_ack;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= 1;
      ack_q          <= 1'b0;
      bus.mem_data_i <= '0;
    end else if (bus.mem_enable_o && !ack_q) begin
      if (cnt >= lat - 1) begin
        ack_q          <= 1'b1;
        cnt            <= 1;
        bus.mem_data_i <= line_pat(bus.mem_addr_o);
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      ack_q <= 1'b0;
    end
  end

  typedef struct {
    bit          ld;
    logic [31:0] data;
    int          stalls;
  } cpu_exp_t;

  typedef struct {
    bit                wr;
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  initial begin : monitor
    int       stalls;
    cpu_exp_t ce;
    mem_exp_t me;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalls = 0;
      end else begin
        if (bus.cpu_MemRead_i || bus.cpu_MemWrite_i) begin
          if (bus.cpu_stall_o) begin
            stalls++;
          end else begin
            if (cpu_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL cpu_unexpected addr=%0h", bus.cpu_addr_i);
            end else begin
              ce = cpu_q.pop_front();
              if (ce.ld)
                chk32("load_data", bus.cpu_data_o, ce.data);
              if (ce.stalls >= 0)
                chk32("stall_cycles", stalls, ce.stalls);
            end
            stalls = 0;
          end
        end
        if (bus.mem_enable_o && bus.mem_ack_i) begin
          if (mem_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mem_unexpected addr=%0h wr=%0d",
                     bus.mem_addr_o, bus.mem_write_o);
          end else begin
            me = mem_q.pop_front();
            chk32("mem_write", 32'(bus.mem_write_o), 32'(me.wr));
            chk32("mem_addr", bus.mem_addr_o, me.addr);
            if (me.wr)
              chk("mem_wdata", bus.mem_data_o, me.data);
          end
        end
      end
    end
  end

  task automatic preload(input logic [3:0] i, input logic w,
                         input logic [STAG_W-1:0] t,
                         input logic [LINE_W-1:0] l,
                         input logic lru);
    @(negedge clk);
    pre_idx  = i;
    pre_way  = w;
    pre_tag  = t;
    pre_line = l;
    pre_lru  = lru;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic expect_mem(input bit wr, input logic [31:0] a,
                            input logic [LINE_W-1:0] d);
    mem_q.push_back('{wr: wr, addr: a, data: d});
  endtask

  task automatic access(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_d,
                        input int exp_st);
    bit done;
    cpu_q.push_back('{ld: !wr, data: exp_d, stalls: exp_st});
    @(posedge clk);
    #1;
    bus.cpu_addr_i     = a;
    bus.cpu_data_i     = d;
    bus.cpu_MemRead_i  = !wr;
    bus.cpu_MemWrite_i = wr;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!bus.cpu_stall_o) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL access_timeout addr=%0h", a);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.cpu_MemRead_i  = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
  endtask

  initial begin : stim
    logic [LINE_W-1:0] l;
    logic [LINE_W-1:0] old;
    bit                seen;
    bus.cpu_addr_i     = '0;
    bus.cpu_data_i     = '0;
    bus.cpu_MemRead_i  = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
    pre_en  = 1'b0;
    pre_clr = 1'b1;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    pre_clr = 1'b0;

    chk32("rst_mem_enable", 32'(bus.mem_enable_o), 0);
    chk32("rst_mem_write", 32'(bus.mem_write_o), 0);
    chk32("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_mem_data", bus.mem_data_o, '0);
    chk32("rst_stall", 32'(bus.cpu_stall_o), 0);
    chk32("rst_sram_write", 32'(bus.sram_write_o), 0);
    chk32("rst_sram_write_hit", 32'(bus.sram_write_hit_o), 0);
    chk32("rst_sram_enable", 32'(bus.sram_enable_o), 0);

    l = '0;
    l[63:32] = 32'hDEAD_BEEF;
    preload(4'd1, 1'b0, {2'b10, 23'h0}, l, 1'b1);
    for (int w = 0; w < 8; w++) old[w*32 +: 32] = 32'h5A5A_0000 + w;
    preload(4'd3, 1'b0, {2'b11, 23'h1}, old, 1'b0);
    preload(4'd3, 1'b1, {2'b10, 23'h5}, line_pat(32'h0000_0A60), 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    access(1'b0, 32'h0000_0024, '0, 32'hDEAD_BEEF, 0);

    expect_mem(1'b0, 32'h0000_0100, '0);
    access(1'b0, 32'h0000_0100, '0, 32'h1000_0100, 8);

    expect_mem(1'b1, 32'h0000_0260, old);
    expect_mem(1'b0, 32'h0000_0460, '0);
    access(1'b0, 32'h0000_0460, '0, 32'h1000_0460, -1);

    expect_mem(1'b0, 32'h0000_0A00, '0);
    access(1'b1, 32'h0000_0A08, 32'h1111_1111, '0, 8);
    access(1'b1, 32'h0000_0A0C, 32'h2222_2222, '0, 0);
    access(1'b0, 32'h0000_0A08, '0, 32'h1111_1111, 0);
    access(1'b0, 32'h0000_0A04, '0, 32'h2000_0A00, 0);
    idle();
    l = line_pat(32'h0000_0A00);
    l[95:64]  = 32'h1111_1111;
    l[127:96] = 32'h2222_2222;
    chk("store_line", s_line[0][0], l);
    chk32("store_valid_dirty", {30'd0, s_v[0][0], s_d[0][0]}, 32'd3);
    chk32("store_tag", {9'd0, s_tag[0][0]}, 32'h5);

    lat = 20;
    @(posedge clk);
    #1;
    bus.cpu_addr_i    = 32'h0000_1120;
    bus.cpu_MemRead_i = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus.mem_enable_o) seen = 1'b1;
    end
    chk32("rm_enable_seen", 32'(seen), 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.cpu_MemRead_i = 1'b0;
    #1;
    chk32("rm_rst_enable", 32'(bus.mem_enable_o), 0);
    chk32("rm_rst_addr", bus.mem_addr_o, 0);
    @(negedge clk);
    chk32("rm_rst_stall", 32'(bus.cpu_stall_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    lat = 5;
    @(posedge clk);
    #1 inj_ack = 1'b1;
    @(negedge clk);
    chk32("late_ack_sram_write", 32'(bus.sram_write_o), 0);
    chk32("late_ack_stall", 32'(bus.cpu_stall_o), 0);
    @(posedge clk);
    #1 inj_ack = 1'b0;
    @(negedge clk);
    chk32("late_ack_enable", 32'(bus.mem_enable_o), 0);
    chk32("late_ack_stall2", 32'(bus.cpu_stall_o), 0);

    expect_mem(1'b0, 32'h0000_1120, '0);
    access(1'b0, 32'h0000_1120, '0, 32'h1000_1120, 8);

    expect_mem(1'b0, 32'h0000_00A0, '0);
    access(1'b0, 32'h0000_00A0, '0, 32'h1000_00A0, 8);
    expect_mem(1'b0, 32'h0000_02A0, '0);
    access(1'b0, 32'h0000_02A0, '0, 32'h1000_02A0, 8);
    access(1'b0, 32'h0000_00A4, '0, 32'h2000_00A0, 0);
    access(1'b0, 32'h0000_02A8, '0, 32'h3000_02A0, 0);
    access(1'b0, 32'h0000_00A0, '0, 32'h1000_00A0, 0);
    idle();

    repeat (3) @(negedge clk);
    chk32("cpu_q_left", cpu_q.size(), 0);
    chk32("mem_q_left", mem_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
